// File: rtl/chnl_tx_master.sv
// Uplink transmitter for one formatter channel: buffers requester words in a FIFO and
// launches them to the slave node with even parity, idle-gap spacing and error stalling.
module chnl_tx_master #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [31:0]      req_data_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    output logic [31:0]      data_o,
    output logic             data_p_o,
    output logic             valid_o,
    input  logic             wait_i,
    input  logic             parity_err_i,
    input  logic             en_i,
    input  logic [3:0]       gap_cycles_i,
    input  logic             inj_perr_i,
    output logic [CNT_W-1:0] sent_cnt_o,
    output logic             busy_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    state_e             state_q, state_d;
    logic [31:0]        mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [31:0]        data_q, data_d;
    logic               par_q, par_d;
    logic               valid_q, valid_d;
    logic               inj_q, inj_d;
    logic [3:0]         gap_q, gap_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               launch_ok;
    logic [31:0]        head;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = req_valid_i && !fifo_full;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    assign launch_ok  = en_i && !fifo_empty && !parity_err_i;

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        par_d   = par_q;
        valid_d = valid_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        inj_d   = inj_q || inj_perr_i;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                valid_d = 1'b0;
                if (launch_ok) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!wait_i) begin
                    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (gap_cycles_i != 4'd0) begin
                        gap_d   = gap_cycles_i;
                        valid_d = 1'b0;
                        state_d = StGap;
                    end else if (!launch_ok) begin
                        valid_d = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            StGap: begin
                valid_d = 1'b0;
                gap_d   = gap_q - 4'd1;
                if (gap_q == 4'd1) begin
                    state_d = launch_ok ? StSend : StIdle;
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
            end
        endcase

        // Any path that lands in SEND from a non-holding position launches a fresh word.
        if (state_d == StSend && !(state_q == StSend && wait_i)) begin
            pop     = 1'b1;
            data_d  = head;
            par_d   = (^head) ^ (inj_q || inj_perr_i);
            valid_d = 1'b1;
            inj_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= req_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            par_q    <= 1'b0;
            valid_q  <= 1'b0;
            inj_q    <= 1'b0;
            gap_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            par_q    <= par_d;
            valid_q  <= valid_d;
            inj_q    <= inj_d;
            gap_q    <= gap_d;
            cnt_q    <= cnt_d;
        end
    end

    assign req_ready_o = !fifo_full;
    assign data_o      = data_q;
    assign data_p_o    = par_q;
    assign valid_o     = valid_q;
    assign sent_cnt_o  = cnt_q;
    assign busy_o      = valid_q || !fifo_empty || (state_q == StGap);

endmodule

// File: tb/tb_chnl_tx_master.sv
// Directed bench for chnl_tx_master: scoreboard of expected {data,parity} per pushed word,
// checked by a slave-side monitor at every completed transfer.
module tb_chnl_tx_master;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] req_data_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] data_o;
    logic        data_p_o;
    logic        valid_o;
    logic        wait_i;
    logic        parity_err_i;
    logic        en_i;
    logic [3:0]  gap_cycles_i;
    logic        inj_perr_i;
    logic [15:0] sent_cnt_o;
    logic        busy_o;

    int checks = 0;
    int failures = 0;
    int perr_seen = 0;
    logic [32:0] sb[$];

    chnl_tx_master #(.DEPTH(8), .CNT_W(16)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .req_data_i   (req_data_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .data_o       (data_o),
        .data_p_o     (data_p_o),
        .valid_o      (valid_o),
        .wait_i       (wait_i),
        .parity_err_i (parity_err_i),
        .en_i         (en_i),
        .gap_cycles_i (gap_cycles_i),
        .inj_perr_i   (inj_perr_i),
        .sent_cnt_o   (sent_cnt_o),
        .busy_o       (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Expected parity is even over the word, flipped when this word carries an injection.
    task automatic push(input logic [31:0] w, input bit flip, input bit track);
        req_data_i  = w;
        req_valid_i = 1'b1;
        if (track && req_ready_o) sb.push_back({w, (^w) ^ flip});
        tick();
        req_valid_i = 1'b0;
    endtask

    // Slave model: a transfer completes on any edge with valid_o && !wait_i.
    always @(negedge clk_i) begin
        if (rst_n_i && valid_o && !wait_i) begin
            logic [32:0] exp_item;
            if ((^{data_o, data_p_o}) != 1'b0) perr_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_transfer", {31'd0, data_o, data_p_o}, 64'hDEAD);
            end else begin
                exp_item = sb.pop_front();
                chk("xfer_data", {32'd0, data_o}, {32'd0, exp_item[32:1]});
                chk("xfer_parity", {63'd0, data_p_o}, {63'd0, exp_item[0]});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int low;
        rst_n_i = 1'b0; req_data_i = '0; req_valid_i = 1'b0; wait_i = 1'b0;
        parity_err_i = 1'b0; en_i = 1'b1; gap_cycles_i = 4'd0; inj_perr_i = 1'b0;
        #1;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data", {32'd0, data_o}, 64'd0);
        chk("rst_par", {63'd0, data_p_o}, 64'd0);
        chk("rst_cnt", {48'd0, sent_cnt_o}, 64'd0);
        chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        tick(); tick();
        rst_n_i = 1'b1;
        tick();

        // Basic burst: launch one edge after push, back-to-back words.
        push(32'h0000_0001, 1'b0, 1'b1);
        chk("burst_lat", {63'd0, valid_o}, 64'd0);
        push(32'h0000_0003, 1'b0, 1'b1);
        chk("burst_v1", {63'd0, valid_o}, 64'd1);
        push(32'hFFFF_FFFF, 1'b0, 1'b1);
        chk("burst_v2", {32'd0, data_o}, 64'h3);
        tick();
        chk("burst_v3", {32'd0, data_o}, 64'hFFFF_FFFF);
        chk("burst_v3_valid", {63'd0, valid_o}, 64'd1);
        tick();
        chk("burst_end_valid", {63'd0, valid_o}, 64'd0);
        chk("burst_cnt", {48'd0, sent_cnt_o}, 64'd3);
        chk("burst_busy", {63'd0, busy_o}, 64'd0);

        // Back-pressure: word held stable while the slave waits.
        wait_i = 1'b1;
        push(32'hA5A5_A5A5, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", {63'd0, valid_o}, 64'd1);
            chk("bp_data", {32'd0, data_o}, 64'hA5A5_A5A5);
            chk("bp_par", {63'd0, data_p_o}, 64'd0);
            chk("bp_cnt", {48'd0, sent_cnt_o}, 64'd3);
            tick();
        end
        wait_i = 1'b0;
        tick();
        chk("bp_cnt_after", {48'd0, sent_cnt_o}, 64'd4);
        chk("bp_valid_after", {63'd0, valid_o}, 64'd0);

        // Gap of 3 low cycles between two words.
        gap_cycles_i = 4'd3;
        push(32'h1234_5678, 1'b0, 1'b1);
        push(32'h0F0F_0F0E, 1'b0, 1'b1);
        chk("gap_first_valid", {63'd0, valid_o}, 64'd1);
        tick();
        gap_cycles_i = 4'd9;
        low = 0;
        while (!valid_o && low < 20) begin
            low++;
            tick();
        end
        chk("gap_low_cycles", low, 3);
        gap_cycles_i = 4'd0;
        for (int i = 0; i < 12; i++) tick();
        chk("gap_cnt", {48'd0, sent_cnt_o}, 64'd6);

        // Gap of 0: no low cycles between the two words.
        push(32'hCAFE_0001, 1'b0, 1'b1);
        push(32'hCAFE_0002, 1'b0, 1'b1);
        tick();
        chk("nogap_valid", {63'd0, valid_o}, 64'd1);
        chk("nogap_data", {32'd0, data_o}, 64'hCAFE_0002);
        tick();
        chk("nogap_end", {63'd0, valid_o}, 64'd0);

        // Injection: pending flag corrupts only the next launched word.
        inj_perr_i = 1'b1;
        tick();
        inj_perr_i = 1'b0;
        tick();
        push(32'h0, 1'b1, 1'b1);
        push(32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) tick();
        chk("inj_slave_errs", perr_seen, 1);
        chk("inj_cnt", {48'd0, sent_cnt_o}, 64'd10);

        // Parity stall: no launches while the slave flags an error.
        parity_err_i = 1'b1;
        push(32'h5555_0000, 1'b0, 1'b1);
        push(32'h5555_0001, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {63'd0, valid_o}, 64'd0);
            chk("stall_busy", {63'd0, busy_o}, 64'd1);
            tick();
        end
        parity_err_i = 1'b0;
        tick();
        chk("stall_launch", {63'd0, valid_o}, 64'd1);
        tick(); tick();
        chk("stall_cnt", {48'd0, sent_cnt_o}, 64'd12);
        chk("sb_drained", sb.size(), 0);

        // Fill with channel disabled; 9th push refused.
        en_i = 1'b0;
        for (int i = 0; i < 8; i++) push(32'h100 + i, 1'b0, 1'b0);
        chk("full_ready", {63'd0, req_ready_o}, 64'd0);
        req_data_i  = 32'hBAD0_BAD0;
        req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        chk("full_busy", {63'd0, busy_o}, 64'd1);
        en_i = 1'b1;
        wait_i = 1'b1;
        tick();
        chk("full_head", {32'd0, data_o}, 64'h100);
        chk("full_ready_after_pop", {63'd0, req_ready_o}, 64'd1);
        tick();
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("mid_rst_valid", {63'd0, valid_o}, 64'd0);
        chk("mid_rst_cnt", {48'd0, sent_cnt_o}, 64'd0);
        chk("mid_rst_ready", {63'd0, req_ready_o}, 64'd1);
        chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chnl_tx_master.md
Name: chnl_tx_master

Overview:
- Uplink transmitter for one channel of the multi-channel data formatter; it drives the slave node's data/parity/valid inputs and honours its wait output.
- Buffers 32-bit words from a local requester in a small FIFO and launches them one at a time.
- Generates even parity per word, with one-shot parity-error injection for test.
- Enforces a programmable minimum idle gap between words and stalls new launches while the slave reports a sticky parity error.

Parameters:
DEPTH, 8, request FIFO depth in words (power of 2, >=2)
CNT_W, 16, width of transferred-word counter

Ports:
clk_i  input  1  clock, rising edge
rst_n_i  input  1  asynchronous active-low reset
req_data_i  input  32  word from requester
req_valid_i  input  1  requester push strobe
req_ready_o  output  1  FIFO not full; push accepted when req_valid_i && req_ready_o
data_o  output  32  word to slave node
data_p_o  output  1  parity bit of data_o
valid_o  output  1  data_o/data_p_o valid
wait_i  input  1  slave back-pressure; transfer occurs on a cycle with valid_o && !wait_i
parity_err_i  input  1  slave sticky parity-error flag
en_i  input  1  channel enable from register
gap_cycles_i  input  4  minimum valid_o-low cycles between consecutive words
inj_perr_i  input  1  one-shot request to corrupt parity of next launched word
sent_cnt_o  output  CNT_W  count of completed transfers, wraps
busy_o  output  1  valid_o || FIFO non-empty || state==GAP

Behaviour:
- Clock is clk_i; reset is asynchronous, active-low on rst_n_i.
- Reset: valid_o=0, data_o=0, data_p_o=0, sent_cnt_o=0, FIFO empty, inj pending=0, state IDLE, so req_ready_o=1 and busy_o=0.
- Reset mid-transfer discards the in-flight word and the FIFO contents.
- req_ready_o = !fifo_full. It is not pop-aware: a full FIFO refuses a push even when a pop occurs in the same cycle.
- Launch condition L = en_i && !fifo_empty && !parity_err_i.
- Launch action:
  - pop FIFO head into data_o, set valid_o=1.
  - data_p_o = (^data) XOR inj, where inj = inj_pending || inj_perr_i.
  - clear inj_pending.
  - Overall parity {data_o,data_p_o} is even when not injected.
- inj_perr_i sets inj_pending, which holds until consumed by a launch. A pulse in the same cycle as a launch is consumed by that launch.
- FSM:
  - IDLE: valid_o=0. If L at the edge, launch and go to SEND. Latency: a word pushed at edge k is driven on valid_o after edge k+1.
  - SEND: valid_o=1.
    - If wait_i: hold state. data_o, data_p_o and valid_o stay stable.
    - If !wait_i: transfer completes and sent_cnt_o increments (mod 2^CNT_W). Then:
      - gap_cycles_i==0 and L: launch the next word back-to-back, stay SEND.
      - gap_cycles_i==0 and !L: go to IDLE, valid_o=0.
      - gap_cycles_i>0: load gap counter with gap_cycles_i, go to GAP, valid_o=0.
  - GAP: valid_o=0 and the counter decrements each cycle.
    - When the counter==1: if L, launch (valid_o rises after exactly gap_cycles_i low cycles) and go to SEND; else go to IDLE.
    - gap_cycles_i changes during GAP do not affect the running count.
- valid_o never deasserts before a transfer completes, regardless of en_i, parity_err_i or inj_perr_i. Clearing en_i or asserting parity_err_i only blocks new launches.
- parity_err_i is sampled only in the launch condition. A held word stays presented while the slave waits; the slave's wait is asserted during its error.
- A FIFO push and pop in the same cycle are both performed and the occupancy is unchanged.
- The FIFO uses wrapping read/write pointers with an extra MSB for the full/empty distinction.
- Combinational outputs: req_ready_o and busy_o. All others are registered.

Test Plan:
- Basic burst: en=1, gap=0, wait=0; push 0x00000001, 0x00000003, 0xFFFFFFFF on consecutive cycles.
  -> valid_o high 3 consecutive cycles from the cycle after the 2nd edge; data_p_o = 1, 0, 0; sent_cnt_o=3; then valid_o=0, busy_o=0.
- Back-pressure: wait_i=1 for 5 cycles while word 0xA5A5A5A5 is presented.
  -> data_o/data_p_o/valid_o constant for all 5 cycles, sent_cnt_o unchanged; transfers on the first wait_i=0 cycle.
- Gap: gap_cycles_i=3; push 2 words, wait=0.
  -> valid_o low exactly 3 cycles between the two transfers; with gap=0, zero low cycles.
- Injection: pulse inj_perr_i, then push 0x00000000 and 0x00000000.
  -> first word data_p_o=1, second data_p_o=0; a slave model flags the error on the first word only.
- Parity stall: parity_err_i=1 with 2 words queued, then cleared after 10 cycles.
  -> no launch while high, busy_o=1; first launch edge after the drop; sent_cnt_o +2.
- Full/reset: en_i=0; push 8 words.
  -> req_ready_o=0 after the 8th push and a 9th push is not accepted.
  - Then set en_i=1, wait_i=1, and assert rst_n_i=0 mid-SEND: valid_o=0, sent_cnt_o=0, req_ready_o=1 immediately.
